// File: rtl/softmax_argmax_reader_if.sv
// Handshake bundle between the softmax stage, the argmax reader and the
// result consumer. The margin signal exists only when TOP2_MARGIN_EN is defined.
interface softmax_argmax_reader_if #(
    parameter int DATAWIDTH = 11,
    parameter int ROWS      = 10,
    parameter int IDXW      = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*DATAWIDTH-1:0] in;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDXW-1:0]           class_idx;
    logic [DATAWIDTH-1:0]      class_prob;
    logic                      low_conf;
`ifdef TOP2_MARGIN_EN
    logic [DATAWIDTH-1:0]      margin;
`endif

    // Reader side
    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, class_idx, class_prob, low_conf
`ifdef TOP2_MARGIN_EN
        , output margin
`endif
    );

    // Producer/consumer side
    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, class_idx, class_prob, low_conf
`ifdef TOP2_MARGIN_EN
        , input margin
`endif
    );
endinterface

// File: rtl/softmax_argmax_reader.sv
// Sequential argmax over a packed softmax probability vector. One row is
// scanned per clock; ties resolve to the lowest index. Optional feature
// TOP2_MARGIN_EN adds best-minus-second-best margin tracking.
module softmax_argmax_reader #(
    parameter int DATAWIDTH = 11,
    parameter int ROWS      = 10,
    parameter int IDXW      = 4,
    parameter int THRESH    = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    softmax_argmax_reader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDXW-1:0]      LAST     = IDXW'(ROWS - 1);
    localparam logic [DATAWIDTH-1:0] THRESH_W = DATAWIDTH'(THRESH);

    state_t                    state_q;
    logic [ROWS*DATAWIDTH-1:0] vec_q;
    logic [IDXW-1:0]           cnt_q;
    logic [DATAWIDTH-1:0]      best_val_q, best_val_d;
    logic [IDXW-1:0]           best_idx_q, best_idx_d;
    logic                      out_valid_q;
    logic [IDXW-1:0]           class_idx_q;
    logic [DATAWIDTH-1:0]      class_prob_q;
    logic                      low_conf_q;
`ifdef TOP2_MARGIN_EN
    logic [DATAWIDTH-1:0]      second_val_q, second_val_d;
    logic [DATAWIDTH-1:0]      margin_q;
`endif

    logic [DATAWIDTH-1:0] rows [ROWS];
    logic [DATAWIDTH-1:0] row_cur;
    logic [DATAWIDTH-1:0] in_row0;

    // Unpack captured vector: row 0 is the most significant slice
    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign rows[g] = vec_q[(ROWS-1-g)*DATAWIDTH +: DATAWIDTH];
    end

    assign in_row0 = bus.in[ROWS*DATAWIDTH-1 -: DATAWIDTH];

    // Compare the current row against the running best (strictly greater wins)
    always_comb begin
        row_cur    = rows[cnt_q];
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
`ifdef TOP2_MARGIN_EN
        second_val_d = second_val_q;
`endif
        if (row_cur > best_val_q) begin
            best_val_d = row_cur;
            best_idx_d = cnt_q;
`ifdef TOP2_MARGIN_EN
            second_val_d = best_val_q;
`endif
        end
`ifdef TOP2_MARGIN_EN
        else if (row_cur > second_val_q) begin
            // A row equal to best lands here, giving a zero margin on ties
            second_val_d = row_cur;
        end
`endif
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            class_idx_q  <= '0;
            class_prob_q <= '0;
            low_conf_q   <= 1'b0;
`ifdef TOP2_MARGIN_EN
            second_val_q <= '0;
            margin_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_q      <= bus.in;
                        best_val_q <= in_row0;
                        best_idx_q <= '0;
                        cnt_q      <= IDXW'(1);
`ifdef TOP2_MARGIN_EN
                        second_val_q <= '0;
`endif
                        if (ROWS == 1) begin
                            // Single-row vector: the result is known at capture
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
                            class_idx_q  <= '0;
                            class_prob_q <= in_row0;
                            low_conf_q   <= (in_row0 < THRESH_W);
`ifdef TOP2_MARGIN_EN
                            margin_q     <= in_row0;
`endif
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
`ifdef TOP2_MARGIN_EN
                    second_val_q <= second_val_d;
`endif
                    if (cnt_q == LAST) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        class_idx_q  <= best_idx_d;
                        class_prob_q <= best_val_d;
                        low_conf_q   <= (best_val_d < THRESH_W);
`ifdef TOP2_MARGIN_EN
                        margin_q     <= best_val_d - second_val_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.class_idx  = class_idx_q;
    assign bus.class_prob = class_prob_q;
    assign bus.low_conf   = low_conf_q;
`ifdef TOP2_MARGIN_EN
    assign bus.margin     = margin_q;
`endif
endmodule

// File: tb/tb_softmax_argmax_reader.sv
// Self-checking bench for softmax_argmax_reader: directed cases plus random
// vectors checked against a behavioural argmax / top-2 model.
module tb_softmax_argmax_reader;
    localparam int DW   = 11;
    localparam int ROWS = 10;
    localparam int IDXW = 4;
    localparam int W    = ROWS * DW;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    softmax_argmax_reader_if #(.DATAWIDTH(DW), .ROWS(ROWS), .IDXW(IDXW)) bus ();

    softmax_argmax_reader #(
        .DATAWIDTH(DW),
        .ROWS     (ROWS),
        .IDXW     (IDXW),
        .THRESH   (512)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_rows(input int unsigned r[ROWS]);
        logic [W-1:0] v;
        v = '0;
        for (int m = 0; m < ROWS; m++) v[(ROWS-m-1)*DW +: DW] = DW'(r[m]);
        return v;
    endfunction

    // Reference: first maximum wins; margin is best minus the largest other row
    task automatic model(input int unsigned r[ROWS], output int unsigned idx,
                         output int unsigned prob, output int unsigned mrg);
        int unsigned sec;
        idx = 0;
        for (int i = 1; i < ROWS; i++) if (r[i] > r[idx]) idx = i;
        prob = r[idx];
        sec = 0;
        for (int i = 0; i < ROWS; i++) if (i != idx && r[i] > sec) sec = r[i];
        mrg = prob - sec;
    endtask

    task automatic run_rows(input int unsigned r[ROWS], input int bp, input string name);
        int unsigned eidx, eprob, emrg;
        int lat;
        model(r, eidx, eprob, emrg);
        @(negedge clk);
        check({name, "_rdy"}, 32'(bus.in_ready), 1);
        bus.in       = pack_rows(r);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in       = W'({$urandom, $urandom, $urandom, $urandom});
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"},  32'(lat), ROWS - 1);
        check({name, "_idx"},  32'(bus.class_idx), eidx);
        check({name, "_prob"}, 32'(bus.class_prob), eprob);
        check({name, "_low"},  32'(bus.low_conf), 32'(eprob < 512));
`ifdef TOP2_MARGIN_EN
        check({name, "_mrg"},  32'(bus.margin), emrg);
`endif
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in       = W'({$urandom, $urandom, $urandom, $urandom});
            check({name, "_bp_v"},   32'(bus.out_valid), 1);
            check({name, "_bp_rdy"}, 32'(bus.in_ready), 0);
            check({name, "_bp_idx"}, 32'(bus.class_idx), eidx);
            check({name, "_bp_prb"}, 32'(bus.class_prob), eprob);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_hs_v"},   32'(bus.out_valid), 0);
        check({name, "_hs_rdy"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    int unsigned r [ROWS];
    int          seen_valid;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check("rst_rdy",  32'(bus.in_ready), 1);
        check("rst_v",    32'(bus.out_valid), 0);
        check("rst_idx",  32'(bus.class_idx), 0);
        check("rst_prob", 32'(bus.class_prob), 0);
        check("rst_low",  32'(bus.low_conf), 0);
`ifdef TOP2_MARGIN_EN
        check("rst_mrg",  32'(bus.margin), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (r[i]) r[i] = 60;
        r[3] = 1500;
        run_rows(r, 0, "single");

        foreach (r[i]) r[i] = 100;
        r[2] = 800; r[7] = 800;
        run_rows(r, 0, "tie");

        foreach (r[i]) r[i] = 0;
        run_rows(r, 0, "zero");
        r[9] = 511;
        run_rows(r, 0, "t511");
        r[9] = 512;
        run_rows(r, 0, "t512");

        foreach (r[i]) r[i] = $urandom_range(0, 2047);
        run_rows(r, 5, "bp");

        foreach (r[i]) r[i] = 0;
        r[1] = 300; r[8] = 1500;
        run_rows(r, 0, "order");

        // Reset four edges into a scan; the previous result is still held
        foreach (r[i]) r[i] = 700;
        @(negedge clk);
        bus.in       = pack_rows(r);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_v",    32'(bus.out_valid), 0);
        check("mrst_rdy",  32'(bus.in_ready), 1);
        check("mrst_idx",  32'(bus.class_idx), 0);
        check("mrst_prob", 32'(bus.class_prob), 0);
        check("mrst_low",  32'(bus.low_conf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        check("mrst_noout", 32'(seen_valid), 0);
        foreach (r[i]) r[i] = 0;
        r[5] = 2000;
        run_rows(r, 0, "after_rst");

        for (int t = 0; t < 20; t++) begin
            foreach (r[i]) begin
                case ($urandom_range(0, 2))
                    0:       r[i] = $urandom_range(0, 2047);
                    1:       r[i] = $urandom_range(0, 4) * 400;
                    default: r[i] = $urandom_range(508, 515);
                endcase
            end
            run_rows(r, $urandom_range(0, 3), $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
